// File: rtl/capsense_csd_prs_precharge.sv
// CapSense CSD precharge clock source: prescaler tick feeding either a fixed
// divide-by-two square wave or a Galois PRS8/PRS16 sequence on prs_out.
module capsense_csd_prs_precharge #(
  parameter int          PrsMode = 1,
  parameter logic [7:0]  Poly8   = 8'hB8,
  parameter logic [15:0] Poly16  = 16'hB400,
  parameter logic [15:0] Seed    = 16'h0001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] period,
  output logic       pulse,
  output logic       prs_out,
  output logic       seq_wrap
);

  // Illegal modes fall through to the fixed divider because neither flag is set.
  localparam bit          IsPrs8   = (PrsMode == 1);
  localparam bit          IsPrs16  = (PrsMode == 2);
  localparam bit          IsPrs    = IsPrs8 || IsPrs16;
  localparam logic [15:0] SeedEff  = IsPrs8 ? {8'h00, Seed[7:0]} : Seed;

  logic [7:0]  cnt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        start_d;
  logic        start_edge;
  logic        tick;
  logic        prs_next;
  logic        wrap_next;

  always_comb begin
    start_edge = enable & start & ~start_d;
    tick       = enable & ~start_edge & (cnt == 8'd0);
  end

  // Next LFSR value; an all-zero register reloads the seed to escape lock-up.
  always_comb begin
    lfsr_next = lfsr;
    if (IsPrs8) begin
      if (lfsr[7:0] == 8'd0)
        lfsr_next = SeedEff;
      else
        lfsr_next = {8'h00, {1'b0, lfsr[7:1]} ^ (lfsr[0] ? Poly8 : 8'h00)};
    end else if (IsPrs16) begin
      if (lfsr == 16'd0)
        lfsr_next = SeedEff;
      else
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? Poly16 : 16'h0000);
    end
  end

  always_comb begin
    if (IsPrs8)
      prs_next = lfsr_next[7];
    else if (IsPrs16)
      prs_next = lfsr_next[15];
    else
      prs_next = ~prs_out;
    wrap_next = tick & IsPrs & (lfsr_next == SeedEff);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= 8'd0;
      lfsr     <= SeedEff;
      prs_out  <= 1'b0;
      pulse    <= 1'b0;
      seq_wrap <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      pulse    <= tick;
      seq_wrap <= wrap_next;
      if (enable)
        start_d <= start;
      if (start_edge) begin
        cnt     <= period;
        lfsr    <= SeedEff;
        prs_out <= 1'b0;
      end else if (enable) begin
        cnt <= (cnt == 8'd0) ? period : cnt - 8'd1;
        if (tick) begin
          prs_out <= prs_next;
          if (IsPrs)
            lfsr <= lfsr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_capsense_csd_prs_precharge.sv
// Self-checking bench: four instances (fixed, PRS8, PRS16, illegal mode) share
// the same stimulus and are compared against a cycle-level behavioural model.
module tb_capsense_csd_prs_precharge;

  localparam int SEED   = 16'h0001;
  localparam int POLY8  = 8'hB8;
  localparam int POLY16 = 16'hB400;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] period;
  logic [3:0] pulse_v;
  logic [3:0] prs_v;
  logic [3:0] wrap_v;

  int checks   = 0;
  int failures = 0;

  int m_cnt, m_sd, m_pulse;
  int m_lfsr[4];
  int m_prs[4];
  int m_wrap[4];

  capsense_csd_prs_precharge #(.PrsMode(0)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .period(period),
    .pulse(pulse_v[0]), .prs_out(prs_v[0]), .seq_wrap(wrap_v[0]));
  capsense_csd_prs_precharge #(.PrsMode(1)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .period(period),
    .pulse(pulse_v[1]), .prs_out(prs_v[1]), .seq_wrap(wrap_v[1]));
  capsense_csd_prs_precharge #(.PrsMode(2)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .period(period),
    .pulse(pulse_v[2]), .prs_out(prs_v[2]), .seq_wrap(wrap_v[2]));
  capsense_csd_prs_precharge #(.PrsMode(3)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .period(period),
    .pulse(pulse_v[3]), .prs_out(prs_v[3]), .seq_wrap(wrap_v[3]));

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int modeOf(input int m);
    return (m == 3) ? 0 : m;
  endfunction

  function automatic int seedOf(input int m);
    return (modeOf(m) == 1) ? (SEED & 'hFF) : SEED;
  endfunction

  task automatic modelReset();
    m_cnt = 0; m_sd = 0; m_pulse = 0;
    for (int m = 0; m < 4; m++) begin
      m_lfsr[m] = seedOf(m); m_prs[m] = 0; m_wrap[m] = 0;
    end
  endtask

  // One rising edge of the reference: tick schedule plus per-mode sequence step.
  task automatic modelStep();
    int edge_det, tick_now, width, poly;
    edge_det = (enable && start && m_sd == 0) ? 1 : 0;
    tick_now = (enable && !edge_det && m_cnt == 0) ? 1 : 0;
    if (enable) m_sd = start;
    m_pulse = tick_now;
    if (edge_det) m_cnt = period;
    else if (enable) m_cnt = (m_cnt == 0) ? int'(period) : m_cnt - 1;
    for (int m = 0; m < 4; m++) begin
      m_wrap[m] = 0;
      if (edge_det) begin
        m_lfsr[m] = seedOf(m); m_prs[m] = 0;
      end else if (tick_now) begin
        if (modeOf(m) == 0) begin
          m_prs[m] = 1 - m_prs[m];
        end else begin
          width = (modeOf(m) == 1) ? 8 : 16;
          poly  = (modeOf(m) == 1) ? POLY8 : POLY16;
          if (m_lfsr[m] == 0) m_lfsr[m] = seedOf(m);
          else if (m_lfsr[m] % 2 == 1) m_lfsr[m] = (m_lfsr[m] / 2) ^ poly;
          else m_lfsr[m] = m_lfsr[m] / 2;
          m_prs[m]  = (m_lfsr[m] >> (width - 1)) & 1;
          m_wrap[m] = (m_lfsr[m] == seedOf(m)) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit do_check);
    @(posedge clock);
    modelStep();
    @(negedge clock);
    if (do_check) begin
      for (int m = 0; m < 4; m++) begin
        checkOutput($sformatf("pulse%0d", m), pulse_v[m], m_pulse);
        checkOutput($sformatf("prs%0d", m), prs_v[m], m_prs[m]);
        checkOutput($sformatf("wrap%0d", m), wrap_v[m], m_wrap[m]);
      end
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    modelReset();
    #2 reset = 1'b0;
  endtask

  initial begin : main
    int exp_prs8[5];
    int cnt_pulses, waited;
    int ticks8, ticks16, last8, wraps8, wraps16, first16, bad8, zero16;
    exp_prs8 = '{1, 0, 0, 0, 1};

    reset = 1'b1; enable = 1'b0; start = 1'b0; period = 8'd0;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("rst_pulse%0d", m), pulse_v[m], 0);
      checkOutput($sformatf("rst_prs%0d", m), prs_v[m], 0);
      checkOutput($sformatf("rst_wrap%0d", m), wrap_v[m], 0);
    end
    checkOutput("rst_lfsr8", u1.lfsr, SEED);

    // PRS8 known sequence, first tick on the first enabled clock
    enable = 1'b1; period = 8'd0; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("seq8_prs_%0d", i), prs_v[1], exp_prs8[i]);
      checkOutput($sformatf("seq8_pulse_%0d", i), pulse_v[1], 1);
    end

    // Fixed divider, period 3: one pulse in every four clocks
    pulseReset();
    period = 8'd3;
    cnt_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1);
      cnt_pulses += pulse_v[0];
    end
    checkOutput("div4_pulses", cnt_pulses, 4);

    // Mid-count period change, then asynchronous reset between edges
    period = 8'd5;
    for (int i = 0; i < 3; i++) applyStimulus(1);
    period = 8'd2;
    for (int i = 0; i < 9; i++) applyStimulus(1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_pulse", pulse_v[1], 0);
    checkOutput("areset_prs", prs_v[1], 0);
    checkOutput("areset_wrap", wrap_v[1], 0);
    checkOutput("areset_lfsr", u1.lfsr, SEED);
    checkOutput("areset_cnt", u1.cnt, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;

    // Start edge mid-sequence: no pulse in the edge clock, next pulse six clocks later
    period = 8'd5;
    for (int i = 0; i < 4; i++) applyStimulus(1);
    start = 1'b1;
    applyStimulus(1);
    checkOutput("start_pulse", pulse_v[1], 0);
    checkOutput("start_lfsr", u1.lfsr, SEED);
    waited = 0;
    do begin
      applyStimulus(1);
      waited++;
    end while (pulse_v[1] == 1'b0 && waited < 20);
    checkOutput("start_next_pulse", waited, 6);

    // Enable gap of ten clocks mid-count
    for (int i = 0; i < 2; i++) applyStimulus(1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1);
    checkOutput("gap_cnt", u1.cnt, m_cnt);
    checkOutput("gap_lfsr", u1.lfsr, m_lfsr[1]);
    enable = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(1);

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) start = ~start;
      if ($urandom_range(31) == 0) period = 8'($urandom_range(7));
      applyStimulus(1);
    end

    // Long free run at period 0: wrap spacing for both PRS lengths
    start = 1'b0; enable = 1'b1; period = 8'd0;
    pulseReset();
    ticks8 = 0; ticks16 = 0; last8 = 0; wraps8 = 0; wraps16 = 0;
    first16 = -1; bad8 = 0; zero16 = 0;
    for (int i = 0; i < 65600; i++) begin
      applyStimulus(0);
      ticks8  += pulse_v[1];
      ticks16 += pulse_v[2];
      if (wrap_v[1]) begin
        if (ticks8 - last8 != 255) bad8++;
        last8 = ticks8;
        wraps8++;
      end
      if (wrap_v[2]) begin
        if (first16 < 0) first16 = ticks16;
        wraps16++;
      end
      if (u2.lfsr == 16'd0) zero16 = 1;
    end
    checkOutput("prs8_wrap_count", wraps8, 257);
    checkOutput("prs8_wrap_spacing", bad8, 0);
    checkOutput("prs16_first_wrap", first16, 65535);
    checkOutput("prs16_wrap_count", wraps16, 1);
    checkOutput("prs16_zero_seen", zero16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capsense_csd_prs_precharge.md
CAPSENSE_CSD_PRS_PRECHARGE -- requirements
Module: capsense_csd_prs_precharge

Interface
REQ-001 Parameter PrsMode, default 1: 0 = fixed divider, 1 = PRS8, 2 = PRS16.
REQ-002 Parameter Poly8, default 8'hB8: Galois tap mask for PRS8.
REQ-003 Parameter Poly16, default 16'hB400: Galois tap mask for PRS16.
REQ-004 Parameter Seed, default 16'h0001: LFSR reload value, nonzero. PRS8 uses Seed[7:0].
REQ-005 clock  in  1  operating clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 enable  in  1  run gate; low freezes all state.
REQ-008 start  in  1  scan request (the same net as the measure stage's start); a rising edge restarts the sequence.
REQ-009 period  in  8  prescaler reload value; tick interval = period+1 clocks.
REQ-010 pulse  out  1  one-clock strobe per tick; drives the measure-stage pulse input.
REQ-011 prs_out  out  1  precharge switch drive.
REQ-012 seq_wrap  out  1  one-clock strobe when the LFSR returns to Seed.

Function
REQ-013 Prescaler: 8-bit down-counter cnt. When cnt==0 and enable=1, the block SHALL reload cnt with period and assert tick; otherwise it SHALL decrement cnt.
REQ-014 pulse SHALL be registered: high in exactly the clock after the clock in which tick was asserted, and low otherwise.
REQ-015 period=0 SHALL produce tick on every enabled clock, so pulse is held high continuously.
REQ-016 A period change SHALL take effect only at the next reload; there is no mid-count reload.
REQ-017 PrsMode 0: prs_out SHALL toggle on every tick, giving a square wave of 2*(period+1) clocks.
REQ-018 PrsMode 1 or 2, on each tick: lfsr SHALL update to (lfsr>>1)^Poly when lfsr[0]=1, else to lfsr>>1, using width 8 or 16.
REQ-019 prs_out SHALL equal the registered LFSR MSB (bit 7 or bit 15) after the update.
REQ-020 Lock-up guard: if lfsr==0 at a tick, it SHALL load Seed instead of shifting.
REQ-021 seq_wrap SHALL pulse in the same clock as pulse when the updated lfsr equals Seed; it is always 0 in PrsMode 0.
REQ-022 start rising edge (start registered internally, detected as start & ~start_d) SHALL load cnt=period and lfsr=Seed and clear prs_out.
REQ-023 No pulse SHALL be generated in the clock in which a start edge is detected; start edge detection SHALL take priority over tick.
REQ-024 start held high or low without an edge SHALL have no effect.
REQ-025 enable=0: cnt, lfsr, prs_out and start_d SHALL hold their values; pulse and seq_wrap SHALL be 0. Operation SHALL resume from the held state when enable returns high.
REQ-026 A start edge occurring while enable=0 SHALL be ignored.
REQ-027 Illegal PrsMode (3) SHALL behave as PrsMode 0.

Reset
REQ-028 While reset=1: cnt=0, lfsr=Seed, prs_out=0, pulse=0, seq_wrap=0, start_d=0.
REQ-029 Reset asserted mid-count SHALL clear the state asynchronously, without waiting for a clock edge.
REQ-030 After release, the first tick SHALL occur on the first enabled clock (cnt=0); its pulse appears one clock later.

Verification
REQ-031 PrsMode 0, period=3, enable=1 after reset -> pulse is high 1 clock in every 4; prs_out is a square wave with an 8-clock period.
REQ-032 PrsMode 1, Seed=01, period=0 -> lfsr sequence B8, 5C, 2E, 17, B3; prs_out = 1,0,0,0,1; seq_wrap fires exactly once per 255 ticks.
REQ-033 PrsMode 2, period=0 -> seq_wrap interval is exactly 65535 ticks, and lfsr never reads 0.
REQ-034 Mid-sequence start 0->1 with period=5 -> lfsr=Seed, no pulse in the edge clock, and the next pulse occurs 6 clocks after the reload.
REQ-035 enable dropped for 10 clocks mid-count -> no pulse during the gap; cnt and lfsr are unchanged; the tick spacing continues seamlessly after re-enable.
REQ-036 Reset pulsed between clock edges during an active PRS8 run -> outputs zero immediately and lfsr=Seed; period changed mid-count is applied only after the current count expires.
